alarm_bank: RTL and testbench
=============================

Name: alarm_bank

Overview:
- Multi-slot alarm controller for the digital-clock display path; successor to the single-alarm selector.
- Holds NUM_ALARMS programmable hour/minute alarms, each with an enable bit.
- Runs the set-mode FSM (hour field, then minute field) with blink-phase outputs, compares against wall time, and drives ring/snooze behaviour.
- Outputs binary fields for the selected slot; 12/24 conversion and seven-segment encoding stay in the existing downstream converters.

Parameters:
- NUM_ALARMS, 4, number of alarm slots (1..16).
- SNOOZE_MIN, 5, snooze length in minutes (1..59).
- RING_SEC, 60, auto-silence timeout in seconds (1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle 1 Hz strobe, aligned with cur_sec update.
- cur_hour  in  7  wall-clock hour 0..23.
- cur_min  in  7  wall-clock minute 0..59.
- cur_sec  in  7  wall-clock second 0..59.
- btn_set  in  1  one-cycle debounced pulse: advance set FSM.
- btn_up  in  1  pulse: increment field being set.
- btn_sel  in  1  pulse: select next slot (IDLE only).
- btn_en  in  1  pulse: toggle enable of selected slot (IDLE only).
- btn_stop  in  1  pulse: cancel ring/snooze.
- btn_snooze  in  1  pulse: snooze while ringing.
- disp_hour  out  7  selected slot hour 0..23.
- disp_min  out  7  selected slot minute.
- disp_pm  out  1  disp_hour > 11.
- disp_slot  out  $clog2(NUM_ALARMS) (min 1)  selected slot index.
- disp_en  out  1  enable bit of selected slot.
- blank_h  out  1  blank hour digits this phase.
- blank_m  out  1  blank minute digits this phase.
- setting  out  1  set FSM not IDLE.
- ring  out  1  alarm sounding.
- ring_slot  out  same as disp_slot  slot that triggered.
- snoozing  out  1  snooze countdown active.

Behaviour:
- Reset (async, rst_n=0): all slots 00:00, all enables 0, selection 0, set FSM IDLE, ring FSM RIDLE, blink phase 0.
  - Output values: disp_hour/disp_min 0, disp_pm 0, disp_slot 0, disp_en 0, blank_h/blank_m 0, setting 0, ring 0, ring_slot 0, snoozing 0.
  - Reset mid-ring or mid-set returns immediately to these values.
- All state is registered. Outputs are registered or decoded directly from registers; button effects are visible the cycle after the pulse.
- Set FSM:
  - IDLE -btn_set-> SET_H -btn_set-> SET_M -btn_set-> IDLE.
  - SET_H: btn_up increments the selected hour, 23 wraps to 0.
  - SET_M: btn_up increments the selected minute, 59 wraps to 0.
  - btn_sel increments the selection, wrapping at NUM_ALARMS-1 to 0; btn_en toggles the enable. Both are ignored outside IDLE.
  - btn_set and btn_up in the same cycle: btn_set wins, btn_up is dropped.
- Blink:
  - Phase register toggles on each tick and is cleared on entry to SET_H/SET_M.
  - blank_h = (SET_H & phase); blank_m = (SET_M & phase).
- Ring FSM:
  - RIDLE -> RINGING on a cycle with tick & cur_sec==0 when an enabled slot matches cur_hour/cur_min.
    - Lowest matching index wins and is latched into ring_slot.
    - The ring timer loads RING_SEC.
    - Matching uses current stored values, even if that slot is being edited.
  - RINGING:
    - ring=1.
    - Timer decrements on tick; reaching 0 -> RIDLE.
    - btn_stop -> RIDLE.
    - btn_snooze -> SNOOZE, countdown loads SNOOZE_MIN*60.
    - btn_stop and btn_snooze in the same cycle: stop wins.
  - SNOOZE:
    - snoozing=1, ring=0.
    - Countdown decrements on tick; reaching 0 -> RINGING with the timer reloaded to RING_SEC.
    - btn_stop -> RIDLE.
    - btn_snooze is ignored.
  - New matches are ignored outside RIDLE.
  - Disabling or editing ring_slot does not cancel an active ring or snooze.
- Set FSM and ring FSM are independent; btn_stop/btn_snooze never affect set state.
- Countdown width: $clog2(SNOOZE_MIN*60+1) bits, saturating at 0.

Decomposition:
- alarm_pkg holds:
  - set-state encodings IDLE/SET_H/SET_M;
  - ring-state encodings RIDLE/RINGING/SNOOZE;
  - constants HOUR_MAX=23, MIN_MAX=59, SEC_PER_MIN=60.
- One sub-module, alarm_ring_ctrl: ring FSM, ring timer and snooze countdown.
  - Inputs: match, match_idx, tick, btn_stop, btn_snooze.
  - Outputs: ring, snoozing, ring_slot.
- The slot register file and set FSM stay in alarm_bank.

Test Plan:
- Reset then select slot 2 via two btn_sel -> disp_slot=2, disp_hour=0, disp_min=0, disp_en=0, setting=0.
- Slot 0 in SET_H: 24 btn_up pulses -> disp_hour returns to 0. btn_set, then 61 btn_up in SET_M -> disp_min=1. btn_set -> setting=0. blank_h toggles per tick only in SET_H.
- Slots 1 and 3 both 07:30 enabled; drive 07:30:00 with tick -> ring=1 next cycle, ring_slot=1. No btn_* for 60 ticks -> ring=0 after the 60th tick.
- Ringing, btn_snooze -> ring=0, snoozing=1. 300 ticks -> ring=1, snoozing=0. btn_stop and btn_snooze together -> ring=0, snoozing=0.
- Slot 0 06:00 with enable=0 -> no ring at 06:00:00. Toggle btn_en -> disp_en=1, rings at the next 06:00:00 match.
- rst_n low mid-SNOOZE -> all outputs return to their reset values asynchronously. After release, no ring until a fresh match.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared encodings and time constants for the multi-slot alarm controller.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2
    } set_state_t;

    typedef enum logic [1:0] {
        RIDLE   = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } ring_state_t;

    localparam int HOUR_MAX    = 23;
    localparam int MIN_MAX     = 59;
    localparam int SEC_PER_MIN = 60;

    // Slot-index width; a single-slot bank still needs a 1-bit index.
    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarm_bank_if.sv
// Button inputs and display/ring outputs of the alarm bank.
interface alarm_bank_if #(
    parameter int NUM_ALARMS = 4
);
    localparam int SW = alarm_pkg::slot_w(NUM_ALARMS);

    logic          btn_set;
    logic          btn_up;
    logic          btn_sel;
    logic          btn_en;
    logic          btn_stop;
    logic          btn_snooze;
    logic [6:0]    disp_hour;
    logic [6:0]    disp_min;
    logic          disp_pm;
    logic [SW-1:0] disp_slot;
    logic          disp_en;
    logic          blank_h;
    logic          blank_m;
    logic          setting;
    logic          ring;
    logic [SW-1:0] ring_slot;
    logic          snoozing;

    modport master (
        output btn_set, btn_up, btn_sel, btn_en, btn_stop, btn_snooze,
        input  disp_hour, disp_min, disp_pm, disp_slot, disp_en,
               blank_h, blank_m, setting, ring, ring_slot, snoozing
    );

    modport slave (
        input  btn_set, btn_up, btn_sel, btn_en, btn_stop, btn_snooze,
        output disp_hour, disp_min, disp_pm, disp_slot, disp_en,
               blank_h, blank_m, setting, ring, ring_slot, snoozing
    );

endinterface

// File: rtl/alarm_ring_ctrl.sv
// Ring/snooze state machine with the auto-silence timer and snooze countdown.
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    parameter int SW         = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          match,
    input  logic [SW-1:0] match_idx,
    input  logic          tick,
    input  logic          btn_stop,
    input  logic          btn_snooze,
    output logic          ring,
    output logic          snoozing,
    output logic [SW-1:0] ring_slot
);

    localparam int SNZ_LOAD = SNOOZE_MIN * SEC_PER_MIN;
    localparam int SNZ_W    = $clog2(SNZ_LOAD + 1);
    localparam int RT_W     = $clog2(RING_SEC + 1);

    ring_state_t      st_q, st_d;
    logic [RT_W-1:0]  rtmr_q;
    logic [SNZ_W-1:0] snz_q;
    logic [SW-1:0]    slot_q;
    logic             rtmr_last, snz_last;

    function automatic logic [RT_W-1:0] ring_dec(input logic [RT_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    function automatic logic [SNZ_W-1:0] snz_dec(input logic [SNZ_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    // A tick with the counter at 1 (or already 0) is the one that reaches 0.
    assign rtmr_last = (rtmr_q <= RT_W'(1));
    assign snz_last  = (snz_q <= SNZ_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_q <= RIDLE;
        else        st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            RIDLE:   if (match) st_d = RINGING;
            RINGING: begin
                if (btn_stop)               st_d = RIDLE;
                else if (btn_snooze)        st_d = SNOOZE;
                else if (tick && rtmr_last) st_d = RIDLE;
            end
            SNOOZE: begin
                if (btn_stop)              st_d = RIDLE;
                else if (tick && snz_last) st_d = RINGING;
            end
            default: st_d = RIDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rtmr_q <= '0;
            snz_q  <= '0;
            slot_q <= '0;
        end else begin
            if (st_q == RIDLE && match)
                slot_q <= match_idx;
            // Reload covers both a fresh match and snooze expiry.
            if (st_d == RINGING && st_q != RINGING)
                rtmr_q <= RT_W'(RING_SEC);
            else if (st_q == RINGING && tick)
                rtmr_q <= ring_dec(rtmr_q);
            if (st_q == RINGING && st_d == SNOOZE)
                snz_q <= SNZ_W'(SNZ_LOAD);
            else if (st_q == SNOOZE && tick)
                snz_q <= snz_dec(snz_q);
        end
    end

    always_comb begin
        ring      = (st_q == RINGING);
        snoozing  = (st_q == SNOOZE);
        ring_slot = slot_q;
    end

endmodule

// File: rtl/alarm_bank.sv
// Multi-slot alarm controller: slot register file, set-mode FSM with blink
// phase, wall-time match, and the ring/snooze controller.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [6:0] cur_hour,
    input  logic [6:0] cur_min,
    input  logic [6:0] cur_sec,
    alarm_bank_if.slave bus
);

    localparam int SW = slot_w(NUM_ALARMS);
    localparam logic [SW-1:0] SEL_LAST = SW'(NUM_ALARMS - 1);

    logic [4:0]            hour_q [NUM_ALARMS];
    logic [5:0]            min_q  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] en_q;
    logic [SW-1:0]         sel_q;
    set_state_t            set_q, set_d;
    logic                  phase_q;

    logic                  enter_set, up_ok;
    logic                  hit, match;
    logic [SW-1:0]         hit_idx;
    logic                  setting_c, blank_h_c, blank_m_c;

    // btn_set has priority over btn_up in the same cycle.
    assign enter_set = bus.btn_set && (set_q != SET_M);
    assign up_ok     = bus.btn_up && !bus.btn_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) set_q <= IDLE;
        else        set_q <= set_d;
    end

    always_comb begin
        set_d = set_q;
        if (bus.btn_set) begin
            case (set_q)
                IDLE:    set_d = SET_H;
                SET_H:   set_d = SET_M;
                default: set_d = IDLE;
            endcase
        end
    end

    always_comb begin
        setting_c = (set_q != IDLE);
        blank_h_c = (set_q == SET_H) && phase_q;
        blank_m_c = (set_q == SET_M) && phase_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                hour_q[i] <= '0;
                min_q[i]  <= '0;
            end
            en_q    <= '0;
            sel_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            if (up_ok && set_q == SET_H)
                hour_q[sel_q] <= (hour_q[sel_q] == 5'(HOUR_MAX)) ? 5'd0 : hour_q[sel_q] + 5'd1;
            if (up_ok && set_q == SET_M)
                min_q[sel_q] <= (min_q[sel_q] == 6'(MIN_MAX)) ? 6'd0 : min_q[sel_q] + 6'd1;
            if (set_q == IDLE) begin
                if (bus.btn_en)
                    en_q[sel_q] <= ~en_q[sel_q];
                if (bus.btn_sel)
                    sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
            end
            if (enter_set)
                phase_q <= 1'b0;
            else if (tick)
                phase_q <= ~phase_q;
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (en_q[i] && {2'b00, hour_q[i]} == cur_hour && {1'b0, min_q[i]} == cur_min) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
        match = hit && tick && (cur_sec == 7'd0);
    end

    alarm_ring_ctrl #(
        .SNOOZE_MIN (SNOOZE_MIN),
        .RING_SEC   (RING_SEC),
        .SW         (SW)
    ) u_ring (
        .clk        (clk),
        .rst_n      (rst_n),
        .match      (match),
        .match_idx  (hit_idx),
        .tick       (tick),
        .btn_stop   (bus.btn_stop),
        .btn_snooze (bus.btn_snooze),
        .ring       (bus.ring),
        .snoozing   (bus.snoozing),
        .ring_slot  (bus.ring_slot)
    );

    assign bus.disp_hour = {2'b00, hour_q[sel_q]};
    assign bus.disp_min  = {1'b0, min_q[sel_q]};
    assign bus.disp_pm   = (hour_q[sel_q] > 5'd11);
    assign bus.disp_slot = sel_q;
    assign bus.disp_en   = en_q[sel_q];
    assign bus.blank_h   = blank_h_c;
    assign bus.blank_m   = blank_m_c;
    assign bus.setting   = setting_c;

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: directed scenarios plus random buttons and
// wall time, checked against a behavioural alarm-clock model.
module tb_alarm_bank;

    localparam int NA  = 4;
    localparam int SNZ = 5;
    localparam int RS  = 60;

    localparam logic [5:0] B_SET = 6'd1;
    localparam logic [5:0] B_UP  = 6'd2;
    localparam logic [5:0] B_SEL = 6'd4;
    localparam logic [5:0] B_EN  = 6'd8;
    localparam logic [5:0] B_STP = 6'd16;
    localparam logic [5:0] B_SNZ = 6'd32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [6:0] cur_hour, cur_min, cur_sec;
    logic       rst_req;

    alarm_bank_if #(.NUM_ALARMS(NA)) bus ();

    alarm_bank #(
        .NUM_ALARMS (NA),
        .SNOOZE_MIN (SNZ),
        .RING_SEC   (RS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .cur_hour (cur_hour),
        .cur_min  (cur_min),
        .cur_sec  (cur_sec),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hour; int min; int pm; int slot; int en;
        int bh; int bm; int setting; int ring; int rslot; int snz;
    } exp_t;

    exp_t sbq[$];
    event probe;
    int   checks = 0;
    int   errors = 0;

    // Reference model: alarm clock state in plain integers.
    int m_h[NA], m_m[NA], m_en[NA];
    int m_sel, m_mode, m_phase;
    int m_ring, m_rleft, m_sleft, m_rslot;

    task automatic model_reset();
        for (int i = 0; i < NA; i++) begin
            m_h[i] = 0; m_m[i] = 0; m_en[i] = 0;
        end
        m_sel = 0; m_mode = 0; m_phase = 0;
        m_ring = 0; m_rleft = 0; m_sleft = 0; m_rslot = 0;
    endtask

    task automatic model_step(input int tk, input int h, input int m, input int s, input logic [5:0] b);
        int hit;
        int mode0;
        hit = -1;
        if (tk != 0 && s == 0)
            for (int i = 0; i < NA; i++)
                if (hit < 0 && m_en[i] != 0 && m_h[i] == h && m_m[i] == m) hit = i;
        if (m_ring == 0) begin
            if (hit >= 0) begin m_ring = 1; m_rleft = RS; m_rslot = hit; end
        end else if (m_ring == 1) begin
            if (b[4]) m_ring = 0;
            else if (b[5]) begin m_ring = 2; m_sleft = SNZ * 60; end
            else if (tk != 0) begin
                m_rleft--;
                if (m_rleft <= 0) m_ring = 0;
            end
        end else begin
            if (b[4]) m_ring = 0;
            else if (tk != 0) begin
                m_sleft--;
                if (m_sleft <= 0) begin m_ring = 1; m_rleft = RS; end
            end
        end
        mode0 = m_mode;
        if (b[0] && mode0 != 2) m_phase = 0;
        else if (tk != 0) m_phase = 1 - m_phase;
        if (b[0]) m_mode = (mode0 + 1) % 3;
        else if (b[1]) begin
            if (mode0 == 1) m_h[m_sel] = (m_h[m_sel] + 1) % 24;
            if (mode0 == 2) m_m[m_sel] = (m_m[m_sel] + 1) % 60;
        end
        if (mode0 == 0) begin
            if (b[3]) m_en[m_sel] = 1 - m_en[m_sel];
            if (b[2]) m_sel = (m_sel + 1) % NA;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.hour    = m_h[m_sel];
        e.min     = m_m[m_sel];
        e.pm      = (m_h[m_sel] >= 12) ? 1 : 0;
        e.slot    = m_sel;
        e.en      = m_en[m_sel];
        e.bh      = (m_mode == 1 && m_phase == 1) ? 1 : 0;
        e.bm      = (m_mode == 2 && m_phase == 1) ? 1 : 0;
        e.setting = (m_mode != 0) ? 1 : 0;
        e.ring    = (m_ring == 1) ? 1 : 0;
        e.rslot   = m_rslot;
        e.snz     = (m_ring == 2) ? 1 : 0;
        sbq.push_back(e);
    endtask

    task automatic drive(input int tk, input int h, input int m, input int s, input logic [5:0] b);
        tick           = tk[0];
        cur_hour       = 7'(h);
        cur_min        = 7'(m);
        cur_sec        = 7'(s);
        bus.btn_set    = b[0];
        bus.btn_up     = b[1];
        bus.btn_sel    = b[2];
        bus.btn_en     = b[3];
        bus.btn_stop   = b[4];
        bus.btn_snooze = b[5];
    endtask

    task automatic cyc(input int tk, input int h, input int m, input int s, input logic [5:0] b);
        @(negedge clk);
        rst_n = rst_req;
        drive(tk, h, m, s, b);
        if (rst_req) model_step(tk, h, m, s, b);
        else         model_reset();
        push_exp();
    endtask

    task automatic press(input logic [5:0] b);
        cyc(0, 12, 34, 56, b);
    endtask

    task automatic tk_at(input int h, input int m, input int s);
        cyc(1, h, m, s, 6'd0);
    endtask

    task automatic set_slot(input int sl, input int hh, input int mm);
        while (m_sel != sl) press(B_SEL);
        press(B_SET);
        repeat ((hh - m_h[sl] + 24) % 24) press(B_UP);
        press(B_SET);
        repeat ((mm - m_m[sl] + 60) % 60) press(B_UP);
        press(B_SET);
    endtask

    // Reset lands mid-cycle; the probe samples before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_req = 1'b0;
        rst_n   = 1'b0;
        drive(0, 0, 0, 0, 6'd0);
        model_reset();
        push_exp();
        ->probe;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp_v, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or probe);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("disp_hour", int'(bus.disp_hour), e.hour);
                chk("disp_min",  int'(bus.disp_min),  e.min);
                chk("disp_pm",   int'(bus.disp_pm),   e.pm);
                chk("disp_slot", int'(bus.disp_slot), e.slot);
                chk("disp_en",   int'(bus.disp_en),   e.en);
                chk("blank_h",   int'(bus.blank_h),   e.bh);
                chk("blank_m",   int'(bus.blank_m),   e.bm);
                chk("setting",   int'(bus.setting),   e.setting);
                chk("ring",      int'(bus.ring),      e.ring);
                chk("ring_slot", int'(bus.ring_slot), e.rslot);
                chk("snoozing",  int'(bus.snoozing),  e.snz);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sbq.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int h, m, s, tk, sl;
        logic [5:0] b;
        rst_req = 1'b1;
        rst_n   = 1'b1;
        drive(0, 0, 0, 0, 6'd0);
        model_reset();
        #1;
        rst_n   = 1'b0;
        rst_req = 1'b0;
        repeat (3) press(6'd0);
        rst_req = 1'b1;
        press(6'd0);

        // Selection walk and wrap.
        press(B_SEL); press(B_SEL); press(6'd0);
        press(B_SEL); press(B_SEL); press(6'd0);

        // Slot 0 field wraps with blink ticks in each mode.
        press(B_SET);
        repeat (3) tk_at(12, 34, 1);
        repeat (24) press(B_UP);
        press(B_SET | B_UP);
        repeat (3) tk_at(12, 34, 2);
        repeat (61) press(B_UP);
        press(B_SET);
        repeat (2) tk_at(12, 34, 3);

        // Two enabled slots at 07:30: lowest index rings, then auto-silences.
        set_slot(1, 7, 30); press(B_EN);
        set_slot(3, 7, 30); press(B_EN);
        tk_at(7, 30, 0);
        repeat (60) tk_at(7, 30, 5);
        press(6'd0);

        // Snooze, expiry back to ringing, then stop beats snooze.
        tk_at(7, 30, 0);
        press(B_SNZ);
        repeat (300) tk_at(7, 31, 5);
        press(6'd0);
        press(B_STP | B_SNZ);
        press(6'd0);

        // Disabled slot is silent until enabled.
        set_slot(0, 6, 0);
        tk_at(6, 0, 0);
        press(6'd0);
        press(B_EN);
        tk_at(6, 0, 0);
        press(B_SNZ);
        repeat (5) tk_at(6, 0, 7);

        // Reset mid-snooze.
        async_reset();
        repeat (2) press(6'd0);
        rst_req = 1'b1;
        press(6'd0);
        repeat (2) tk_at(6, 0, 0);

        // Random buttons and wall time, biased toward stored slot times.
        for (int i = 0; i < 3000; i++) begin
            tk = ($urandom_range(0, 1) == 0) ? 1 : 0;
            if ($urandom_range(0, 3) == 0) begin
                sl = $urandom_range(0, NA - 1);
                h = m_h[sl]; m = m_m[sl]; s = 0;
            end else begin
                h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
            end
            b = 6'd0;
            b[0] = ($urandom_range(0, 15) == 0);
            b[1] = ($urandom_range(0, 3) == 0);
            b[2] = ($urandom_range(0, 15) == 0);
            b[3] = ($urandom_range(0, 11) == 0);
            b[4] = ($urandom_range(0, 39) == 0);
            b[5] = ($urandom_range(0, 19) == 0);
            cyc(tk, h, m, s, b);
        end
        press(6'd0);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
